// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity modes, baud divider.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BRK    = 3'd5
   } rx_state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   // Clock cycles per oversampling tick, rounded to nearest, never below 1.
   function automatic int uart_div(input int clk, input int baud, input int os);
      longint den;
      longint q;
      den = longint'(baud) * longint'(os);
      q   = (longint'(clk) + den / 2) / den;
      return (q < 1) ? 1 : int'(q);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle tick every DIV cycles while clr is low.
// Latency: first tick DIV cycles after clr drops; tick is combinational from the count.
// Backpressure: none; clr holds the count at zero and suppresses tick.
// Ports: clk/rst clock and async active-high reset, clr synchronous clear, tick output.
module uart_baud_tick #(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = !clr && (cnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clr || cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with majority-vote sampling, false-start and break handling.
// Latency: 3 cycles line edge to FSM reaction; 1 cycle from last stop commit to rx_valid/overrun.
// Backpressure: one-word holding register; a frame completing while the word is unaccepted is dropped (overrun pulse).
// Ports: sys_clk/sys_rst, uart_rx serial in, rx_data/rx_valid/rx_ready word handshake,
//        parity_err/frame_err qualify the held word, overrun pulses on a dropped frame.
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   input  logic                 uart_rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun
);

   localparam int DIV = uart_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int M   = OVERSAMPLE / 2;
   localparam int SCW = $clog2(OVERSAMPLE);

   localparam logic [SCW-1:0] SC_S0   = SCW'(M - 1);
   localparam logic [SCW-1:0] SC_S1   = SCW'(M);
   localparam logic [SCW-1:0] SC_CMT  = SCW'(M + 1);
   localparam logic [SCW-1:0] SC_END  = SCW'(OVERSAMPLE - 1);
   localparam logic [3:0]     BIT_LST = 4'(DATA_BITS - 1);
   localparam logic           STP_LST = 1'(STOP_BITS - 1);

   rx_state_t state, state_nxt;

   logic                 rx_m, rx_s, rx_prev;
   logic                 tick;
   logic [SCW-1:0]       sc;
   logic                 samp0, samp1;
   logic                 maj, commit, bit_end;
   logic [DATA_BITS-1:0] shreg;
   logic [3:0]           bit_cnt;
   logic                 stop_cnt;
   logic                 perr_acc, ferr_acc, ferr_now;
   logic                 frame_done;

   // Two-flop synchroniser plus one history flop for falling-edge detection.
   // All reset high so that reset release never looks like a start edge.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         rx_m    <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_m    <= uart_rx;
         rx_s    <= rx_m;
         rx_prev <= rx_s;
      end
   end

   // Tick counter is held cleared in IDLE so each frame is phase-aligned to its start edge.
   uart_baud_tick #(.DIV(DIV)) u_tick (
      .clk  (sys_clk),
      .rst  (sys_rst),
      .clr  (state == ST_IDLE),
      .tick (tick)
   );

   assign maj      = (samp0 & samp1) | (samp0 & rx_s) | (samp1 & rx_s);
   assign commit   = tick && (sc == SC_CMT);
   assign bit_end  = tick && (sc == SC_END);
   assign ferr_now = ferr_acc | ~maj;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      frame_done = 1'b0;
      case (state)
         ST_IDLE:   if (rx_prev && !rx_s) state_nxt = ST_START;
         ST_START: begin
            if (commit && maj)
               state_nxt = ST_IDLE;
            else if (bit_end)
               state_nxt = ST_DATA;
         end
         ST_DATA: begin
            if (bit_end && bit_cnt == BIT_LST)
               state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
         end
         ST_PARITY: if (bit_end) state_nxt = ST_STOP;
         ST_STOP: begin
            // Completion happens at the commit point so a back-to-back start
            // edge in the second half of the stop bit is not missed.
            if (commit && stop_cnt == STP_LST) begin
               frame_done = 1'b1;
               state_nxt  = (ferr_now && shreg == '0) ? ST_BRK : ST_IDLE;
            end
         end
         ST_BRK:    if (rx_s) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Bit timing, sampling and shift register.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         sc       <= '0;
         samp0    <= 1'b1;
         samp1    <= 1'b1;
         shreg    <= '0;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
         perr_acc <= 1'b0;
         ferr_acc <= 1'b0;
      end else if (state == ST_IDLE) begin
         sc       <= '0;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
         perr_acc <= 1'b0;
         ferr_acc <= 1'b0;
      end else begin
         if (tick)
            sc <= (sc == SC_END) ? '0 : sc + 1'b1;
         if (tick && sc == SC_S0)
            samp0 <= rx_s;
         if (tick && sc == SC_S1)
            samp1 <= rx_s;
         if (state == ST_DATA && commit)
            shreg <= {maj, shreg[DATA_BITS-1:1]};
         if (state == ST_DATA && bit_end)
            bit_cnt <= bit_cnt + 1'b1;
         if (state == ST_PARITY && commit)
            perr_acc <= (PARITY != PAR_NONE) && ((^shreg ^ maj) != (PARITY == PAR_ODD));
         if (state == ST_STOP && commit)
            ferr_acc <= ferr_now;
         if (state == ST_STOP && bit_end)
            stop_cnt <= 1'b1;
      end
   end

   // Output holding register: accept a new word when empty or draining this cycle.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (frame_done) begin
            if (!rx_valid || rx_ready) begin
               rx_data    <= shreg;
               parity_err <= (PARITY != PAR_NONE) && perr_acc;
               frame_err  <= ferr_now;
               rx_valid   <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three configurations (8N1, 8E1, 9N2) on separate lines.
// Latency: frame completion expected 32*last_bit+23 cycles after the start bit is driven.
// Backpressure: rx_ready per instance, held low in the overrun sequence.
module tb_uart_rx_cfg;
   import uart_pkg::*;

   localparam int CF = 32_000_000;
   localparam int BR = 1_000_000;
   localparam int OS = 16;
   localparam int BT = 32;   // cycles per bit

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] line;
   logic [2:0] rdy;
   logic [7:0] d0, d1;
   logic [8:0] d2;
   logic [2:0] vld, perr, ferr, ovr;
   logic [8:0] dw [3];

   always #5 clk = ~clk;

   uart_rx_cfg #(.CLK_FREQ(CF), .BAUD(BR), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
      .sys_clk(clk), .sys_rst(rst), .uart_rx(line[0]), .rx_data(d0), .rx_valid(vld[0]),
      .rx_ready(rdy[0]), .parity_err(perr[0]), .frame_err(ferr[0]), .overrun(ovr[0]));
   uart_rx_cfg #(.CLK_FREQ(CF), .BAUD(BR), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
      .sys_clk(clk), .sys_rst(rst), .uart_rx(line[1]), .rx_data(d1), .rx_valid(vld[1]),
      .rx_ready(rdy[1]), .parity_err(perr[1]), .frame_err(ferr[1]), .overrun(ovr[1]));
   uart_rx_cfg #(.CLK_FREQ(CF), .BAUD(BR), .OVERSAMPLE(OS), .DATA_BITS(9), .PARITY(0), .STOP_BITS(2)) u_9n2 (
      .sys_clk(clk), .sys_rst(rst), .uart_rx(line[2]), .rx_data(d2), .rx_valid(vld[2]),
      .rx_ready(rdy[2]), .parity_err(perr[2]), .frame_err(ferr[2]), .overrun(ovr[2]));

   assign dw[0] = {1'b0, d0};
   assign dw[1] = {1'b0, d1};
   assign dw[2] = d2;

   // Cycle counter and output monitor (sampled on the falling edge).
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         rise_cnt [3] = '{0, 0, 0};
   int         hi_cnt   [3] = '{0, 0, 0};
   int         ovr_cnt  [3] = '{0, 0, 0};
   int         rise_cyc [3] = '{0, 0, 0};
   int         ovr_cyc  [3] = '{0, 0, 0};
   logic [8:0] cap_data [3] = '{9'h0, 9'h0, 9'h0};
   logic       cap_perr [3] = '{1'b0, 1'b0, 1'b0};
   logic       cap_ferr [3] = '{1'b0, 1'b0, 1'b0};
   logic [2:0] vld_q = 3'b000;

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (vld[i] === 1'b1) hi_cnt[i] = hi_cnt[i] + 1;
         if (vld[i] === 1'b1 && vld_q[i] !== 1'b1) begin
            rise_cnt[i] = rise_cnt[i] + 1;
            rise_cyc[i] = cyc;
            cap_data[i] = dw[i];
            cap_perr[i] = perr[i];
            cap_ferr[i] = ferr[i];
         end
         if (ovr[i] === 1'b1) begin
            ovr_cnt[i] = ovr_cnt[i] + 1;
            ovr_cyc[i] = cyc;
         end
         vld_q[i] = vld[i];
      end
   end

   int n_pass = 0;
   int n_tot  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot = n_tot + 1;
      if (act !== exp)
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      else
         n_pass = n_pass + 1;
   endtask

   task automatic hold(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // pbit < 0 means no parity bit; t0 is the cycle stamp when the start bit went out.
   task automatic send_frame(input int idx, input logic [8:0] data, input int nbits,
                             input int pbit, input int nstop, input logic stop_lvl,
                             output int t0);
      @(posedge clk); #1;
      t0 = cyc;
      line[idx] = 1'b0;
      hold(BT);
      for (int b = 0; b < nbits; b++) begin
         line[idx] = data[b];
         hold(BT);
      end
      if (pbit >= 0) begin
         line[idx] = (pbit != 0);
         hold(BT);
      end
      for (int s = 0; s < nstop; s++) begin
         line[idx] = stop_lvl;
         hold(BT);
      end
      line[idx] = 1'b1;
   endtask

   typedef struct {
      int         dut;
      logic [8:0] data;
      int         nbits;
      int         pbit;
      int         nstop;
      logic       stop_lvl;
      logic [8:0] exp_data;
      logic       exp_perr;
      logic       exp_ferr;
      int         exp_lat;
   } vec_t;

   localparam int NV = 8;
   vec_t vt [NV];

   initial begin
      #600_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1, r, h, o;
      string nm;

      vt[0] = '{0, 9'h0A5, 8, -1, 1, 1'b1, 9'h0A5, 1'b0, 1'b0, 311};
      vt[1] = '{0, 9'h03C, 8, -1, 1, 1'b0, 9'h03C, 1'b0, 1'b1, 311};
      vt[2] = '{1, 9'h05A, 8,  1, 1, 1'b1, 9'h05A, 1'b1, 1'b0, 343};
      vt[3] = '{1, 9'h05A, 8,  0, 1, 1'b1, 9'h05A, 1'b0, 1'b0, 343};
      vt[4] = '{1, 9'h007, 8,  1, 1, 1'b1, 9'h007, 1'b0, 1'b0, 343};
      vt[5] = '{1, 9'h080, 8,  0, 1, 1'b1, 9'h080, 1'b1, 1'b0, 343};
      vt[6] = '{2, 9'h1A5, 9, -1, 2, 1'b1, 9'h1A5, 1'b0, 1'b0, 375};
      vt[7] = '{2, 9'h155, 9, -1, 2, 1'b0, 9'h155, 1'b0, 1'b1, 375};

      rst  = 1'b1;
      line = 3'b111;
      rdy  = 3'b111;
      hold(3);
      chk("reset_valid", 32'(vld[0]), 32'd0);
      chk("reset_data",  32'(d0), 32'd0);
      chk("reset_perr",  32'(perr[0]), 32'd0);
      chk("reset_ferr",  32'(ferr[0]), 32'd0);
      chk("reset_ovr",   32'(ovr[0]), 32'd0);
      chk("reset_state", 32'(u_8n1.state), 32'(ST_IDLE));
      rst = 1'b0;
      hold(5);

      // Table-driven frames across all three configurations.
      for (int v = 0; v < NV; v++) begin
         r = rise_cnt[vt[v].dut];
         h = hi_cnt[vt[v].dut];
         send_frame(vt[v].dut, vt[v].data, vt[v].nbits, vt[v].pbit, vt[v].nstop, vt[v].stop_lvl, t0);
         hold(BT);
         $sformat(nm, "vec%0d", v);
         chk({nm, "_count"}, 32'(rise_cnt[vt[v].dut] - r), 32'd1);
         chk({nm, "_width"}, 32'(hi_cnt[vt[v].dut] - h), 32'd1);
         chk({nm, "_data"},  32'(cap_data[vt[v].dut]), 32'(vt[v].exp_data));
         chk({nm, "_perr"},  32'(cap_perr[vt[v].dut]), 32'(vt[v].exp_perr));
         chk({nm, "_ferr"},  32'(cap_ferr[vt[v].dut]), 32'(vt[v].exp_ferr));
         chk({nm, "_lat"},   32'(rise_cyc[vt[v].dut] - t0), 32'(vt[v].exp_lat));
      end

      // Short low glitch is rejected as a false start.
      r = rise_cnt[0];
      @(posedge clk); #1;
      line[0] = 1'b0;
      hold(8);
      line[0] = 1'b1;
      hold(2 * BT);
      chk("glitch_nofrm", 32'(rise_cnt[0] - r), 32'd0);
      chk("glitch_idle",  32'(u_8n1.state), 32'(ST_IDLE));
      send_frame(0, 9'h03C, 8, -1, 1, 1'b1, t0);
      hold(BT);
      chk("glitch_next_cnt",  32'(rise_cnt[0] - r), 32'd1);
      chk("glitch_next_data", 32'(cap_data[0]), 32'h3C);

      // Overrun: second frame dropped while the first is unaccepted.
      rdy[0] = 1'b0;
      r = rise_cnt[0];
      o = ovr_cnt[0];
      send_frame(0, 9'h011, 8, -1, 1, 1'b1, t0);
      send_frame(0, 9'h022, 8, -1, 1, 1'b1, t1);
      hold(BT);
      chk("ovr_valid_held", 32'(vld[0]), 32'd1);
      chk("ovr_data_held",  32'(d0), 32'h11);
      chk("ovr_rise_cnt",   32'(rise_cnt[0] - r), 32'd1);
      chk("ovr_pulses",     32'(ovr_cnt[0] - o), 32'd1);
      chk("ovr_lat",        32'(ovr_cyc[0] - t1), 32'd311);
      rdy[0] = 1'b1;
      hold(1);
      chk("ovr_drain", 32'(vld[0]), 32'd0);
      send_frame(0, 9'h033, 8, -1, 1, 1'b1, t0);
      hold(BT);
      chk("ovr_next_cnt",  32'(rise_cnt[0] - r), 32'd2);
      chk("ovr_next_data", 32'(cap_data[0]), 32'h33);

      // Break: line held low for 20 bit times yields exactly one frame.
      r = rise_cnt[0];
      @(posedge clk); #1;
      line[0] = 1'b0;
      hold(20 * BT);
      chk("brk_state", 32'(u_8n1.state), 32'(ST_BRK));
      line[0] = 1'b1;
      hold(BT);
      chk("brk_count", 32'(rise_cnt[0] - r), 32'd1);
      chk("brk_data",  32'(cap_data[0]), 32'h00);
      chk("brk_ferr",  32'(cap_ferr[0]), 32'd1);
      send_frame(0, 9'h03C, 8, -1, 1, 1'b1, t0);
      hold(BT);
      chk("brk_next_cnt",  32'(rise_cnt[0] - r), 32'd2);
      chk("brk_next_data", 32'(cap_data[0]), 32'h3C);
      chk("brk_next_ferr", 32'(cap_ferr[0]), 32'd0);

      // Reset asserted during data bit 4 aborts the frame asynchronously.
      r = rise_cnt[0];
      fork
         send_frame(0, 9'h0F0, 8, -1, 1, 1'b1, t0);
         begin
            hold(5 * BT + 12);
            #2;
            rst = 1'b1;
            #1;
            chk("rst_async_data",  32'(d0), 32'd0);
            chk("rst_async_valid", 32'(vld[0]), 32'd0);
            chk("rst_async_ferr",  32'(ferr[0]), 32'd0);
            chk("rst_async_state", 32'(u_8n1.state), 32'(ST_IDLE));
         end
      join
      hold(4);
      rst = 1'b0;
      hold(4);
      chk("rst_abort_nofrm", 32'(rise_cnt[0] - r), 32'd0);
      send_frame(0, 9'h0C3, 8, -1, 1, 1'b1, t0);
      hold(BT);
      chk("rst_next_cnt",  32'(rise_cnt[0] - r), 32'd1);
      chk("rst_next_data", 32'(cap_data[0]), 32'hC3);
      chk("rst_next_lat",  32'(rise_cyc[0] - t0), 32'd311);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
